alu_seq_ctrl: RTL and testbench



---
 rtl/alu_seq_ctrl_pkg.sv | 36 +++
 rtl/alu_seq_ctrl_if.sv | 22 ++
 rtl/alu_seq_ctrl_btn_debounce.sv | 48 ++++
 rtl/alu_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_alu_seq_ctrl.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared types for the ALU sequencing controller: FSM encoding,
// SWITCH control-word field positions and a field decoder.
package alu_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_CAPT = 2'd2
    } state_e;

    localparam int SW_W         = 10;
    localparam int OP_LSB       = 0;
    localparam int CIN_BIT      = 3;
    localparam int LED_LSB      = 4;
    localparam int HEX_SEL_LSB  = 6;
    localparam int HEX_MODE_LSB = 8;

    typedef struct packed {
        logic [1:0] hex_mode;
        logic [1:0] hex_sel;
        logic [1:0] led_sel;
        logic       carry_in;
        logic [2:0] alu_op;
    } cfg_t;

    function automatic cfg_t decode_cfg(input logic [SW_W-1:0] sw);
        cfg_t c;
        c.alu_op   = sw[OP_LSB +: 3];
        c.carry_in = sw[CIN_BIT];
        c.led_sel  = sw[LED_LSB +: 2];
        c.hex_sel  = sw[HEX_SEL_LSB +: 2];
        c.hex_mode = sw[HEX_MODE_LSB +: 2];
        return c;
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Controller-to-ALU bundle: operands, opcode, start strobe and result.
interface alu_seq_ctrl_if #(
    parameter int N = 10
);
    logic [N-1:0] a_reg;
    logic [N-1:0] b_reg;
    logic [2:0]   alu_op;
    logic         carry_in;
    logic         alu_start;
    logic [N-1:0] alu_result;
    logic         alu_cout;

    modport master (
        output a_reg, b_reg, alu_op, carry_in, alu_start,
        input  alu_result, alu_cout
    );

    modport slave (
        input  a_reg, b_reg, alu_op, carry_in, alu_start,
        output alu_result, alu_cout
    );
endinterface

// File: rtl/alu_seq_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, hold-time debounce counter,
// one-cycle pulse on the debounced rising edge.
module btn_debounce #(
    parameter int DEB_CYCLES = 50000,
    parameter int DEB_W      = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    logic [1:0]       sync_q;
    logic             stable_q, stable_d;
    logic             prev_q;
    logic [DEB_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[0], btn_i};
            stable_q <= stable_d;
            prev_q   <= stable_q;
            cnt_q    <= cnt_d;
        end
    end

    // Any cycle agreeing with the stable level restarts the hold count.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync_q[1] == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
            stable_d = ~stable_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign pulse_o = stable_q & ~prev_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Board-level sequencer: debounced buttons load operands from SWITCH,
// fire the ALU and capture its result over a three-state cycle.
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int N          = 10,
    parameter int DEB_CYCLES = 50000,
    parameter int DEB_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SW_W-1:0]      SWITCH,
    input  logic                 B0,
    input  logic                 B1,
    input  logic                 B2,
    alu_seq_ctrl_if.master       alu,
    output logic [1:0]           led_sel,
    output logic [1:0]           hex_sel,
    output logic [1:0]           hex_mode,
    output logic [N-1:0]         res_reg,
    output logic                 res_cout,
    output logic                 res_valid,
    output logic                 busy
);

    logic [2:0]   pulse;
    state_e       state_q, state_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    cfg_t         cfg_q, cfg_d;
    logic [N-1:0] res_q, res_d;
    logic         rcout_q, rcout_d;
    logic         rvalid_q, rvalid_d;
    logic [2:0]   pend_q, pend_d;
    logic         start;
    logic         do_a, do_b, do_x;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb0 (
        .clk(clk), .rst_n(rst_n), .btn_i(B0), .pulse_o(pulse[0])
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb1 (
        .clk(clk), .rst_n(rst_n), .btn_i(B1), .pulse_o(pulse[1])
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb2 (
        .clk(clk), .rst_n(rst_n), .btn_i(B2), .pulse_o(pulse[2])
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cfg_q    <= '0;
            res_q    <= '0;
            rcout_q  <= 1'b0;
            rvalid_q <= 1'b0;
            pend_q   <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cfg_q    <= cfg_d;
            res_q    <= res_d;
            rcout_q  <= rcout_d;
            rvalid_q <= rvalid_d;
            pend_q   <= pend_d;
        end
    end

    assign do_a = pulse[0] | pend_q[0];
    assign do_b = pulse[1] | pend_q[1];
    assign do_x = pulse[2] | pend_q[2];

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cfg_d    = cfg_q;
        res_d    = res_q;
        rcout_d  = rcout_q;
        rvalid_d = rvalid_q;
        pend_d   = pend_q;
        start    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                pend_d[1:0] = 2'b00;
                if (do_a) begin
                    a_d      = SWITCH[N-1:0];
                    rvalid_d = 1'b0;
                end
                if (do_b) begin
                    b_d      = SWITCH[N-1:0];
                    rvalid_d = 1'b0;
                end
                // Execute waits a cycle so it sees freshly loaded operands.
                if (do_x) begin
                    if (do_a || do_b) begin
                        pend_d[2] = 1'b1;
                    end else begin
                        pend_d[2] = 1'b0;
                        cfg_d     = decode_cfg(SWITCH);
                        start     = 1'b1;
                        state_d   = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                pend_d  = pend_q | pulse;
                state_d = ST_CAPT;
            end
            ST_CAPT: begin
                pend_d   = pend_q | pulse;
                res_d    = alu.alu_result;
                rcout_d  = alu.alu_cout;
                rvalid_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign alu.a_reg     = a_q;
    assign alu.b_reg     = b_q;
    assign alu.alu_op    = cfg_q.alu_op;
    assign alu.carry_in  = cfg_q.carry_in;
    assign alu.alu_start = start;
    assign led_sel       = cfg_q.led_sel;
    assign hex_sel       = cfg_q.hex_sel;
    assign hex_mode      = cfg_q.hex_mode;
    assign res_reg       = res_q;
    assign res_cout      = rcout_q;
    assign res_valid     = rvalid_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a short debounce window and
// an adding ALU model driven through the interface.
module tb_alu_seq_ctrl;

    localparam int N = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [9:0]   SWITCH = '0;
    logic         B0 = 1'b0, B1 = 1'b0, B2 = 1'b0;
    logic [1:0]   led_sel, hex_sel, hex_mode;
    logic [N-1:0] res_reg;
    logic         res_cout, res_valid, busy;
    int           tests = 0;
    int           failed = 0;

    alu_seq_ctrl_if #(.N(N)) alu ();

    assign {alu.alu_cout, alu.alu_result} = {1'b0, alu.a_reg} + {1'b0, alu.b_reg};

    alu_seq_ctrl #(.N(N), .DEB_CYCLES(4), .DEB_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .SWITCH(SWITCH),
        .B0(B0), .B1(B1), .B2(B2), .alu(alu),
        .led_sel(led_sel), .hex_sel(hex_sel), .hex_mode(hex_mode),
        .res_reg(res_reg), .res_cout(res_cout),
        .res_valid(res_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cyc(2);
        chk("rst_a", 32'(alu.a_reg), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(res_valid), 0);
        rst_n = 1'b1;
        cyc(2);

        // Load A = 5: pulse six edges after raise, a_reg on the seventh
        SWITCH = 10'd5; B0 = 1'b1;
        cyc(6);
        chk("a_early", 32'(alu.a_reg), 0);
        cyc(1);
        chk("a_load", 32'(alu.a_reg), 5);
        cyc(3); B0 = 1'b0;
        cyc(8);

        SWITCH = 10'd1; B1 = 1'b1;
        cyc(7);
        chk("b_load", 32'(alu.b_reg), 1);
        chk("valid_lo", 32'(res_valid), 0);
        cyc(3); B1 = 1'b0;
        cyc(8);

        // Execute with SWITCH = 0
        SWITCH = 10'd0; B2 = 1'b1;
        cyc(5);
        chk("start_early", 32'(alu.alu_start), 0);
        cyc(1);
        chk("start", 32'(alu.alu_start), 1);
        chk("busy_t", 32'(busy), 0);
        cyc(1);
        chk("start_drop", 32'(alu.alu_start), 0);
        chk("busy_1", 32'(busy), 1);
        chk("op0", 32'(alu.alu_op), 0);
        cyc(1);
        chk("busy_2", 32'(busy), 1);
        cyc(1);
        chk("busy_3", 32'(busy), 0);
        chk("res0", 32'(res_reg), 6);
        chk("cout0", 32'(res_cout), 0);
        chk("valid0", 32'(res_valid), 1);
        cyc(1); B2 = 1'b0;
        cyc(8);

        // Bounce shorter than the debounce window
        SWITCH = 10'd7;
        for (int i = 0; i < 10; i++) begin
            B0 = ~B0;
            cyc(2);
        end
        B0 = 1'b0;
        cyc(10);
        chk("bounce_a", 32'(alu.a_reg), 5);
        chk("bounce_valid", 32'(res_valid), 1);

        // B1 and B2 coincide: load first, execute next cycle
        SWITCH = 10'd3; B1 = 1'b1; B2 = 1'b1;
        cyc(6);
        chk("co_start_lo", 32'(alu.alu_start), 0);
        cyc(1);
        chk("co_b", 32'(alu.b_reg), 3);
        chk("co_start", 32'(alu.alu_start), 1);
        chk("co_valid", 32'(res_valid), 0);
        cyc(3);
        chk("co_res", 32'(res_reg), 8);
        chk("co_op", 32'(alu.alu_op), 3);
        chk("co_valid2", 32'(res_valid), 1);
        B1 = 1'b0; B2 = 1'b0;
        cyc(8);

        // B0 lands during EXEC; fields from 0x39D
        SWITCH = 10'h39D; B2 = 1'b1;
        cyc(1); B0 = 1'b1;
        cyc(5);
        chk("ex_start", 32'(alu.alu_start), 1);
        cyc(1);
        chk("ex_busy", 32'(busy), 1);
        chk("ex_op", 32'(alu.alu_op), 5);
        chk("ex_cin", 32'(alu.carry_in), 1);
        chk("ex_led", 32'(led_sel), 1);
        chk("ex_hsel", 32'(hex_sel), 2);
        chk("ex_hmode", 32'(hex_mode), 3);
        SWITCH = 10'd9;
        cyc(1);
        chk("ex_a_hold", 32'(alu.a_reg), 5);
        cyc(1);
        chk("ex_a_hold2", 32'(alu.a_reg), 5);
        chk("ex_valid", 32'(res_valid), 1);
        cyc(1);
        chk("ex_a_new", 32'(alu.a_reg), 9);
        chk("ex_valid_clr", 32'(res_valid), 0);
        B0 = 1'b0; B2 = 1'b0;
        cyc(10);

        // Reset during CAPT
        SWITCH = 10'd0; B2 = 1'b1;
        cyc(8);
        chk("pre_rst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy2", 32'(busy), 0);
        chk("rst_a2", 32'(alu.a_reg), 0);
        chk("rst_b2", 32'(alu.b_reg), 0);
        chk("rst_hmode", 32'(hex_mode), 0);
        B2 = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(10);
        chk("post_valid", 32'(res_valid), 0);
        chk("post_res", 32'(res_reg), 0);
        chk("post_busy", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
